decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INSTR_W, 16, instruction width.
- OPCODE_W, 4, opcode field width.
- REG_AW, 3, register address width.
- IMM_W, 8, immediate width.
- OP_COUNT, 16, number of legal opcodes.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- in_instr, in, INSTR_W, fetched instruction.
- in_valid, in, 1, in_instr valid.
- in_ready, out, 1, stage can accept.
- flush, in, 1, discard all buffered entries.
- out_opcode, out, OPCODE_W, opcode.
- out_rs1, out, REG_AW, source register 1.
- out_rs2, out, REG_AW, source register 2.
- out_rd, out, REG_AW, destination register.
- out_imm, out, IMM_W, immediate.
- out_illegal, out, 1, opcode >= OP_COUNT.
- out_valid, out, 1, decoded entry valid.
- out_ready, in, 1, consumer accepts.

Function
REQ-003 Field slicing SHALL be:
- opcode = instr[OPCODE_W-1:0].
- rs1 = next REG_AW bits above opcode; rs2 = next REG_AW bits above rs1; rdf = next REG_AW bits above rs2.
- imm = instr[INSTR_W-1 -: IMM_W].
REQ-004 out_rd SHALL be rs1 when opcode==OP_LDI, rs2 when opcode==OP_LD, and rdf otherwise.
REQ-005 Elaboration SHALL fail if OPCODE_W+3*REG_AW > INSTR_W or IMM_W > INSTR_W.
REQ-006 Decode happens on entry; the buffer SHALL store decoded fields, not raw instructions.
REQ-007 Buffer SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL.
REQ-008 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-009 in_ready SHALL be a registered signal, equal to (state != FULL).
REQ-010 State transitions:
- EMPTY -> ONE on input transfer.
- ONE -> FULL on input without output.
- ONE -> EMPTY on output without input.
- ONE stays ONE on simultaneous input and output.
- FULL -> ONE on output.
REQ-011 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-012 Output order SHALL be strict FIFO.
REQ-013 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-014 A flush sampled high SHALL force the state to EMPTY next cycle and drop any same-cycle input transfer; in_ready SHALL be 1 afterwards.
REQ-015 out_illegal SHALL be valid only with out_valid; illegal entries still pass through.

Reset
REQ-016 While rst is sampled high, the state SHALL become EMPTY, with in_ready=1, out_valid=0, out_illegal=0 and all field outputs 0.
REQ-017 Reset mid-operation SHALL discard buffered entries with no output transfer; rst has priority over flush.

Configuration
REQ-018 With macro DECODE_HAZARD_EN defined, a load-use interlock SHALL be included:
- On an output transfer of an OP_LD entry, the stage records its rd and sets a pending bit.
- If the next head entry has rs1 or rs2 equal to the recorded rd, out_valid SHALL be held 0 for exactly one cycle (bubble); the pending bit then clears.
- Pending SHALL also clear after any non-matching output transfer, on flush, and on rst.
REQ-019 Without DECODE_HAZARD_EN, no interlock logic SHALL exist and out_valid = (state != EMPTY).

Structure
REQ-020 OP_LDI, OP_LD and default field widths SHALL live in the shared instruction-set package; decode_stage imports it.
REQ-021 Combinational field extraction SHALL be one sub-module, decode_fields, instantiated once at the input; the buffer and interlock stay in decode_stage.

Verification
REQ-022 Directed scenarios:
- Defaults, instr={8'hA5, rdf=3, rs2=2, rs1=1, opcode=OP_LDI} -> after 1 edge: out_rd=1, out_imm=8'hA5, out_valid=1.
- Same encoding with opcode=OP_LD -> out_rd=2; any other legal opcode -> out_rd=3.
- out_ready=0 while 3 back-to-back instructions are offered -> 2 accepted, in_ready=0 after the second; releasing out_ready -> instructions emerge in order with no loss or duplication.
- Buffer FULL, flush=1 for one cycle -> next cycle out_valid=0, in_ready=1; the instruction offered during the flush cycle is never output.
- OP_COUNT=8, opcode=4'hC -> out_illegal=1 with out_valid=1.
- DECODE_HAZARD_EN: OP_LD to rd=5 followed by an instruction with rs1=5 -> exactly one cycle of out_valid=0 between them; with rs1=4 -> no bubble.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_pkg
//  Brief    : Shared instruction-set constants, default field widths and the
//             skid-buffer state encoding used by the decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    // Default field widths of the instruction encoding
    localparam int unsigned INSTR_W_DEF  = 16;
    localparam int unsigned OPCODE_W_DEF = 4;
    localparam int unsigned REG_AW_DEF   = 3;
    localparam int unsigned IMM_W_DEF    = 8;
    localparam int unsigned OP_COUNT_DEF = 16;

    // Opcodes whose destination register comes from a source-register slot
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage : decode_stage_pkg
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_if
//  Brief    : Fetch-side and consumer-side handshake bundle of the decode
//             stage. The stage connects through 'slave', the surrounding
//             environment (fetch unit plus consumer) through 'master'.
//  Revision : 1.0 - initial release
// ============================================================================
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned OPCODE_W = OPCODE_W_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned IMM_W    = IMM_W_DEF
);
    logic [INSTR_W-1:0]  in_instr;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [OPCODE_W-1:0] out_opcode;
    logic [REG_AW-1:0]   out_rs1;
    logic [REG_AW-1:0]   out_rs2;
    logic [REG_AW-1:0]   out_rd;
    logic [IMM_W-1:0]    out_imm;
    logic                out_illegal;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_instr, in_valid, flush, out_ready,
        input  in_ready, out_opcode, out_rs1, out_rs2, out_rd, out_imm,
               out_illegal, out_valid
    );

    modport slave (
        input  in_instr, in_valid, flush, out_ready,
        output in_ready, out_opcode, out_rs1, out_rs2, out_rd, out_imm,
               out_illegal, out_valid
    );
endinterface : decode_stage_if
`default_nettype wire

// File: rtl/decode_stage_fields.sv
`default_nettype none
// ============================================================================
//  Module   : decode_fields
//  Brief    : Purely combinational slicing of a raw instruction into opcode,
//             register addresses, immediate and an illegal-opcode flag, with
//             destination selection for the load opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned OPCODE_W = OPCODE_W_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned IMM_W    = IMM_W_DEF,
    parameter int unsigned OP_COUNT = OP_COUNT_DEF
) (
    input  wire logic [INSTR_W-1:0]  i_instr,
    output logic      [OPCODE_W-1:0] o_opcode,
    output logic      [REG_AW-1:0]   o_rs1,
    output logic      [REG_AW-1:0]   o_rs2,
    output logic      [REG_AW-1:0]   o_rd,
    output logic      [IMM_W-1:0]    o_imm,
    output logic                     o_illegal
);
    localparam logic [OPCODE_W-1:0] c_op_ldi = OPCODE_W'(OP_LDI);
    localparam logic [OPCODE_W-1:0] c_op_ld  = OPCODE_W'(OP_LD);

    // Encodings that do not fit the instruction word are rejected at build time
    if ((OPCODE_W + 3 * REG_AW > INSTR_W) || (IMM_W > INSTR_W)) begin : g_bad_cfg
        $error("decode_fields: field widths exceed INSTR_W");
    end

    logic [REG_AW-1:0] w_rdf;
    logic [31:0]       w_opcode_ext;

    assign o_opcode     = i_instr[OPCODE_W-1:0];
    assign o_rs1        = i_instr[OPCODE_W +: REG_AW];
    assign o_rs2        = i_instr[OPCODE_W + REG_AW +: REG_AW];
    assign w_rdf        = i_instr[OPCODE_W + 2 * REG_AW +: REG_AW];
    assign o_imm        = i_instr[INSTR_W-1 -: IMM_W];
    assign w_opcode_ext = 32'(o_opcode);
    assign o_illegal    = (w_opcode_ext >= 32'(OP_COUNT));

    // Loads name their destination in a source slot; everything else uses rdf
    always_comb begin
        o_rd = w_rdf;
        if (o_opcode == c_op_ldi) begin
            o_rd = o_rs1;
        end else if (o_opcode == c_op_ld) begin
            o_rd = o_rs2;
        end
    end
endmodule : decode_fields
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Brief    : Instruction decode stage with a two-entry skid buffer holding
//             already-decoded entries, one cycle of latency and strict FIFO
//             order. Defining DECODE_HAZARD_EN adds a load-use interlock that
//             inserts a one-cycle bubble after a load whose destination is a
//             source of the following entry.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned INSTR_W  = INSTR_W_DEF,
    parameter int unsigned OPCODE_W = OPCODE_W_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned IMM_W    = IMM_W_DEF,
    parameter int unsigned OP_COUNT = OP_COUNT_DEF
) (
    input  wire logic     clk,
    input  wire logic     rst,
    decode_stage_if.slave bus
);
    // Packed entry layout: {illegal, imm, rd, rs2, rs1, opcode}
    localparam int c_rs1_lsb = OPCODE_W;
    localparam int c_rs2_lsb = OPCODE_W + REG_AW;
    localparam int c_rd_lsb  = OPCODE_W + 2 * REG_AW;
    localparam int c_imm_lsb = OPCODE_W + 3 * REG_AW;
    localparam int c_entry_w = OPCODE_W + 3 * REG_AW + IMM_W + 1;

    logic [OPCODE_W-1:0]  w_dec_opcode;
    logic [REG_AW-1:0]    w_dec_rs1;
    logic [REG_AW-1:0]    w_dec_rs2;
    logic [REG_AW-1:0]    w_dec_rd;
    logic [IMM_W-1:0]     w_dec_imm;
    logic                 w_dec_illegal;
    logic [c_entry_w-1:0] w_dec_entry;

    buf_state_e           r_state;
    buf_state_e           w_state_nxt;
    logic                 r_in_ready;
    logic [c_entry_w-1:0] r_head;
    logic [c_entry_w-1:0] r_skid;
    logic                 w_load_head;
    logic                 w_head_from_skid;
    logic                 w_load_skid;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_out_valid;
    logic                 w_has_entry;

    decode_fields #(
        .INSTR_W  (INSTR_W),
        .OPCODE_W (OPCODE_W),
        .REG_AW   (REG_AW),
        .IMM_W    (IMM_W),
        .OP_COUNT (OP_COUNT)
    ) u_fields (
        .i_instr   (bus.in_instr),
        .o_opcode  (w_dec_opcode),
        .o_rs1     (w_dec_rs1),
        .o_rs2     (w_dec_rs2),
        .o_rd      (w_dec_rd),
        .o_imm     (w_dec_imm),
        .o_illegal (w_dec_illegal)
    );

    assign w_dec_entry = {w_dec_illegal, w_dec_imm, w_dec_rd, w_dec_rs2, w_dec_rs1, w_dec_opcode};

    // A flush drops any instruction offered in the same cycle
    assign w_in_xfer   = bus.in_valid & r_in_ready & ~bus.flush;
    assign w_out_xfer  = w_out_valid & bus.out_ready;
    assign w_has_entry = (r_state != ST_EMPTY);

`ifdef DECODE_HAZARD_EN
    localparam logic [OPCODE_W-1:0] c_op_ld = OPCODE_W'(OP_LD);

    logic              r_pend;
    logic [REG_AW-1:0] r_pend_rd;
    logic              w_bubble;

    // Head depends on the load that just left: hide it for one cycle
    assign w_bubble = r_pend & w_has_entry &
                      ((r_head[c_rs1_lsb +: REG_AW] == r_pend_rd) |
                       (r_head[c_rs2_lsb +: REG_AW] == r_pend_rd));
    assign w_out_valid = w_has_entry & ~w_bubble;

    // Remember the destination of a departing load until the next entry is judged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_pend_rd <= '0;
        end else if (bus.flush) begin
            r_pend    <= 1'b0;
        end else if (w_out_xfer) begin
            r_pend    <= (r_head[OPCODE_W-1:0] == c_op_ld);
            r_pend_rd <= r_head[c_rd_lsb +: REG_AW];
        end else if (w_bubble) begin
            r_pend    <= 1'b0;
        end
    end
`else
    assign w_out_valid = w_has_entry;
`endif

    // Occupancy transitions and which storage slot captures/moves data
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_head = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ST_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State register; in_ready is registered from the upcoming occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Decoded-entry storage: head drives the outputs, skid holds the second entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_dec_entry;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec_entry;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_opcode  = r_head[OPCODE_W-1:0];
    assign bus.out_rs1     = r_head[c_rs1_lsb +: REG_AW];
    assign bus.out_rs2     = r_head[c_rs2_lsb +: REG_AW];
    assign bus.out_rd      = r_head[c_rd_lsb +: REG_AW];
    assign bus.out_imm     = r_head[c_imm_lsb +: IMM_W];
    assign bus.out_illegal = r_head[c_entry_w-1] & w_out_valid;
endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Brief    : Self-checking bench for decode_stage: a queue-based reference
//             of the stage compared every cycle, directed scenarios with
//             literal expectations, then randomized traffic with flush/reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int unsigned TB_OP_COUNT = 8;

    typedef struct {
        logic [3:0] op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [7:0] imm;
        logic       ill;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.INSTR_W(16), .OPCODE_W(4), .REG_AW(3), .IMM_W(8)) bus ();

    decode_stage #(
        .INSTR_W  (16),
        .OPCODE_W (4),
        .REG_AW   (3),
        .IMM_W    (8),
        .OP_COUNT (TB_OP_COUNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the field rules
    function automatic ent_t decode(input logic [15:0] i);
        ent_t e;
        e.op  = i[3:0];
        e.rs1 = i[6:4];
        e.rs2 = i[9:7];
        e.imm = i[15:8];
        if (e.op == OP_LDI)     e.rd = e.rs1;
        else if (e.op == OP_LD) e.rd = e.rs2;
        else                    e.rd = i[12:10];
        e.ill = (32'(e.op) >= TB_OP_COUNT);
        return e;
    endfunction

    // Transaction-level model: a queue of at most two decoded entries
    ent_t       q[$];
    bit         m_ready = 1'b1;
    bit         m_valid = 1'b0;
    bit         m_pend  = 1'b0;
    logic [2:0] m_pend_rd = '0;
    bit         chk_en  = 1'b0;

    function automatic bit hold_now();
`ifdef DECODE_HAZARD_EN
        return m_pend && (q.size() > 0) && (q[0].rs1 == m_pend_rd || q[0].rs2 == m_pend_rd);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        bit in_x, out_x, held;
        held  = hold_now();
        in_x  = bus.in_valid && m_ready && !bus.flush;
        out_x = m_valid && bus.out_ready;
        if (rst || bus.flush) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            if (out_x) begin
                m_pend    = (q[0].op == OP_LD);
                m_pend_rd = q[0].rd;
                void'(q.pop_front());
            end else if (held) begin
                m_pend = 1'b0;
            end
            if (in_x) q.push_back(decode(bus.in_instr));
        end
        m_ready = (q.size() < 2);
        m_valid = (q.size() > 0) && !hold_now();
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, m_ready);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("opcode", bus.out_opcode, q[0].op);
                chk("rs1", bus.out_rs1, q[0].rs1);
                chk("rs2", bus.out_rs2, q[0].rs2);
                chk("rd", bus.out_rd, q[0].rd);
                chk("imm", bus.out_imm, q[0].imm);
                chk("illegal", bus.out_illegal, q[0].ill);
            end else begin
                chk("illegal_idle", bus.out_illegal, 1'b0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        ent_t       e;
        logic [15:0] ri;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_illegal", bus.out_illegal, 0);
        chk("rst_fields", {bus.out_opcode, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm}, 0);
        chk_en = 1'b1;

        // Pin the reference decode
        e = decode(16'hA5F1); chk("model_ldi_rd", e.rd, 7);
        e = decode(16'hA5F2); chk("model_ld_rd", e.rd, 3);
        e = decode(16'hA5F5); chk("model_alu_rd", e.rd, 1);
        e = decode(16'h000C); chk("model_ill", e.ill, 1);

        // Back-to-back decode, consumer always ready
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'hA5F1; cyc();
        chk("ldi_valid", bus.out_valid, 1);
        chk("ldi_rd", bus.out_rd, 7);
        chk("ldi_imm", bus.out_imm, 8'hA5);
        bus.in_instr  = 16'hA5F5; cyc();
        chk("alu_rd", bus.out_rd, 1);
        chk("alu_rs1", bus.out_rs1, 7);
        bus.in_instr  = 16'hA5F2; cyc();
        chk("ld_rd", bus.out_rd, 3);
        bus.in_instr  = 16'h000C; cyc();
        chk("ill_valid", bus.out_valid, 1);
        chk("ill_flag", bus.out_illegal, 1);
        bus.in_valid  = 1'b0; cyc();
        chk("drained", bus.out_valid, 0);

        // Backpressure: three offered, two accepted, order preserved
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h1234; cyc();
        bus.in_instr  = 16'h2345; cyc();
        chk("bp_full_ready", bus.in_ready, 0);
        chk("bp_head_first", bus.out_opcode, 4);
        bus.in_instr  = 16'h3456; cyc();
        chk("bp_hold_head", bus.out_opcode, 4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1; cyc();
        chk("bp_second", bus.out_opcode, 5);
        cyc();
        chk("bp_no_third", bus.out_valid, 0);

        // Flush from FULL and from ONE with a same-cycle offer
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h1111; cyc();
        bus.in_instr  = 16'h2222; cyc();
        bus.flush     = 1'b1;
        bus.in_instr  = 16'h3333; cyc();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1; cyc();
        chk("fl_nothing", bus.out_valid, 0);
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h4444; cyc();
        bus.flush     = 1'b1;
        bus.in_instr  = 16'h5555; cyc();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        chk("fl_one_drop", bus.out_valid, 0);
        cyc();

`ifdef DECODE_HAZARD_EN
        // Load to r5 followed by a reader of r5: exactly one bubble
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0282; cyc();
        chk("hz_ld_out", bus.out_valid, 1);
        bus.in_instr = 16'h0050; cyc();
        bus.in_valid = 1'b0;
        chk("hz_bubble", bus.out_valid, 0);
        cyc();
        chk("hz_after", bus.out_valid, 1);
        chk("hz_after_rs1", bus.out_rs1, 5);
        cyc();
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h0282; cyc();
        bus.in_instr = 16'h0040; cyc();
        bus.in_valid = 1'b0;
        chk("hz_no_bubble", bus.out_valid, 1);
        cyc();
`endif

        // Randomized traffic with occasional flush and reset
        repeat (3000) begin
            ri = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ri[3:0] = OP_LD;
            if ($urandom_range(0, 1) == 0) ri[9:4] = 6'($urandom_range(0, 7));
            bus.in_instr  = ri;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 249) == 0);
            cyc();
        end
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_decode_stage
`default_nettype wire
